// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage in front of the 8-bit functional units.
// Takes one operation at a time over a valid/ready handshake, executes
// ADD/SUB/AND/OR/XOR in a single cycle, runs MUL as a multi-cycle operation
// (MUL_LATENCY cycles), and holds the result until writeback takes it.
// Optional build macro ALU_FLAGS_EN adds registered out_zero/out_carry flags.
module alu_issue_ctrl #(
  parameter int WIDTH       = 8,
  parameter int MUL_LATENCY = 3   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef ALU_FLAGS_EN
  output logic             out_zero,
  output logic             out_carry,
`endif
  output logic             out_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  // A single-cycle multiplier is indistinguishable from the other units.
  localparam bit         MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic [3:0] CNT_INIT  = 4'(MUL_LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
`ifdef ALU_FLAGS_EN
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             res_carry;
  logic [2*WIDTH-1:0] prod;
`endif

  logic             accept;
  logic             exec;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign exec      = (state_q == S_EXEC);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_err   = err_q;
`ifdef ALU_FLAGS_EN
  assign out_zero  = zero_q;
  assign out_carry = carry_q;
`endif

  // While a MUL is in flight the shared datapath sees the latched operands;
  // otherwise it sees the live request so single-cycle ops finish on accept.
  assign op_sel = exec ? OP_MUL : in_op;
  assign a_sel  = exec ? a_q    : in_a;
  assign b_sel  = exec ? b_q    : in_b;

  // Shared functional-unit datapath: result, error and optional flags.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    res_data = '0;
    res_err  = 1'b0;
`ifdef ALU_FLAGS_EN
    res_carry = 1'b0;
    prod      = '0;
`endif
    case (op_sel)
`ifdef ALU_FLAGS_EN
      OP_ADD: {res_carry, res_data} = {1'b0, a_sel} + {1'b0, b_sel};
      OP_SUB: {res_carry, res_data} = {1'b0, a_sel} + {1'b0, ~b_sel} + (WIDTH+1)'(1);
      OP_MUL: begin
        prod      = {{WIDTH{1'b0}}, a_sel} * {{WIDTH{1'b0}}, b_sel};
        res_data  = prod[WIDTH-1:0];
        res_carry = |prod[2*WIDTH-1:WIDTH];
      end
`else
      OP_ADD: res_data = a_sel + b_sel;
      OP_SUB: res_data = a_sel - b_sel;
      OP_MUL: res_data = a_sel * b_sel;
`endif
      OP_AND: res_data = a_sel & b_sel;
      OP_OR:  res_data = a_sel | b_sel;
      OP_XOR: res_data = a_sel ^ b_sel;
      default: res_err = 1'b1;
    endcase
  end

  // Next-state and result-capture decisions for the issue sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef ALU_FLAGS_EN
    zero_d  = zero_q;
    carry_d = carry_q;
`endif
    if (exec) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = S_DONE;
        data_d  = res_data;
        err_d   = res_err;
`ifdef ALU_FLAGS_EN
        zero_d  = (res_data == '0);
        carry_d = res_carry;
`endif
      end
    end else if (accept) begin
      if ((in_op == OP_MUL) && MUL_MULTI) begin
        state_d = S_EXEC;
        cnt_d   = CNT_INIT;
      end else begin
        state_d = S_DONE;
        data_d  = res_data;
        err_d   = res_err;
`ifdef ALU_FLAGS_EN
        zero_d  = (res_data == '0);
        carry_d = res_carry;
`endif
      end
    end else if ((state_q != S_DONE) || out_ready) begin
      // Result taken with nothing new, or an unused encoding: go idle.
      state_d = S_IDLE;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef ALU_FLAGS_EN
      zero_q  <= zero_d;
      carry_q <= carry_d;
`endif
    end
  end

  // Operand capture for the multi-cycle multiplier.
  always_ff @(posedge clk) begin
    // NOTE: operand registers are left unreset; they are only read in EXEC,
    // which is always entered through an accept that loads them.
    if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases with literal
// expectations plus randomized traffic checked against a transaction-level
// model (pending result + countdown + held flag) every cycle.
module tb_alu_issue_ctrl;

  localparam int WIDTH = 8;
  localparam int LAT   = 3;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
`ifdef ALU_FLAGS_EN
  logic             out_zero, out_carry;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: a result either waits (m_wait cycles) or is held.
  bit m_held = 1'b0;
  int m_wait = 0;
  int m_data, m_err, m_zero, m_carry;
  int p_data, p_err, p_zero, p_carry;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(WIDTH), .MUL_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef ALU_FLAGS_EN
    .out_zero  (out_zero),
    .out_carry (out_carry),
`endif
    .out_err   (out_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference for one operation.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int d, output int e, output int z, output int c);
    e = 0;
    c = 0;
    case (op)
      0: begin d = (a + b) % MOD; c = int'((a + b) >= MOD); end
      1: begin d = (a - b + MOD) % MOD; c = int'(a >= b); end
      2: begin d = (a * b) % MOD; c = int'((a * b) >= MOD); end
      3: d = a & b;
      4: d = a | b;
      5: d = a ^ b;
      default: begin d = 0; e = 1; end
    endcase
    z = int'(d == 0);
  endfunction

  // One clock cycle: drive, compare against the model, then advance it.
  task automatic step(input bit r, input bit v, input int op, input int a, input int b,
                      input bit ordy);
    bit m_ready;
    bit acc;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_op     = op[2:0];
    in_a      = a[WIDTH-1:0];
    in_b      = b[WIDTH-1:0];
    out_ready = ordy;
    #1;
    m_ready = (m_wait == 0) && (!m_held || ordy);
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, m_held);
    if (m_held) begin
      check("out_data", out_data, m_data);
      check("out_err", out_err, m_err);
`ifdef ALU_FLAGS_EN
      check("out_zero", out_zero, m_zero);
      check("out_carry", out_carry, m_carry);
`endif
    end
    acc = v && m_ready && !r;
    @(posedge clk);
    if (r) begin
      m_held = 1'b0;
      m_wait = 0;
    end else begin
      if (m_held && ordy) m_held = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_held = 1'b1;
          m_data = p_data; m_err = p_err; m_zero = p_zero; m_carry = p_carry;
        end
      end
      if (acc) begin
        ref_op(op & 7, a & (MOD - 1), b & (MOD - 1), p_data, p_err, p_zero, p_carry);
        if ((op & 7) == 2 && LAT > 1) begin
          m_wait = LAT - 1;
        end else begin
          m_held = 1'b1;
          m_data = p_data; m_err = p_err; m_zero = p_zero; m_carry = p_carry;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);

    // ADD 200+100 -> 44, then idle.
    step(0, 1, 0, 200, 100, 1);
    #1; check("add_valid", out_valid, 1); check("add_data", out_data, 44); check("add_err", out_err, 0);
    step(0, 0, 0, 0, 0, 1);
    #1; check("add_idle", out_valid, 0);

    // SUB 5-10 -> 251.
    step(0, 1, 1, 5, 10, 1);
    #1; check("sub_data", out_data, 251);
    step(0, 0, 0, 0, 0, 1);

    // MUL 20*13 -> 4 after LAT cycles.
    step(0, 1, 2, 20, 13, 1);
    #1; check("mul_busy1", out_valid, 0);
    step(0, 1, 0, 1, 1, 1);
    step(0, 1, 0, 1, 1, 1);
    #1; check("mul_valid", out_valid, 1); check("mul_data", out_data, 4);
    step(0, 0, 0, 0, 0, 1);

    // Backpressure: XOR held while out_ready=0, in_a changing.
    step(0, 1, 5, 8'hF0, 8'h3C, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, i * 37, 3, 0);
    #1; check("bp_data", out_data, 8'hCC);
    step(0, 0, 0, 0, 0, 1);
    #1; check("bp_idle", out_valid, 0);

    // Back-to-back AND then OR.
    step(0, 1, 3, 8'hF0, 8'h3C, 1);
    #1; check("b2b_and", out_data, 8'h30);
    step(0, 1, 4, 8'hF0, 8'h3C, 1);
    #1; check("b2b_or_valid", out_valid, 1); check("b2b_or", out_data, 8'hFC);
    step(0, 0, 0, 0, 0, 1);

    // Illegal opcode.
    step(0, 1, 7, 9, 9, 1);
    #1; check("ill_data", out_data, 0); check("ill_err", out_err, 1);
    step(0, 0, 0, 0, 0, 1);

    // Reset during MUL execution abandons it.
    step(0, 1, 2, 7, 7, 1);
    step(1, 0, 0, 0, 0, 1);
    #1; check("rst_exec_valid", out_valid, 0); check("rst_exec_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

`ifdef ALU_FLAGS_EN
    step(0, 1, 0, 8'h80, 8'h80, 1);
    #1; check("fl_add_data", out_data, 0); check("fl_add_zero", out_zero, 1);
    check("fl_add_carry", out_carry, 1);
    step(0, 1, 1, 3, 3, 1);
    #1; check("fl_sub0_zero", out_zero, 1); check("fl_sub0_carry", out_carry, 1);
    step(0, 1, 1, 2, 3, 1);
    #1; check("fl_subn_data", out_data, 255); check("fl_subn_carry", out_carry, 0);
    step(0, 0, 0, 0, 0, 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
